alu_issue_stage: RTL
====================

# alu_issue_stage

ID/EX issue stage for the RV32I 5-stage pipeline: decodes the ID-stage instruction into the 5-bit ALU opcode and operand pair that the EX-stage ALU consumes. It applies EX/MEM and MEM/WB forwarding and detects load-use hazards. It also registers everything into the ID/EX pipeline register under stall/flush control. It sits between the register file read and the ALU.

## Interface
- No parameters. Data width is fixed at 32.
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_inst  in  32  instruction word
- id_pc  in  32  instruction PC
- id_rs1_data, id_rs2_data  in  32 each  register file read data
- mem_fwd_en  in  1  EX/MEM stage writes rd
- mem_fwd_rd  in  5  EX/MEM stage destination
- mem_fwd_data  in  32  EX/MEM stage result
- wb_fwd_en  in  1  MEM/WB stage writes rd
- wb_fwd_rd  in  5  MEM/WB stage destination
- wb_fwd_data  in  32  MEM/WB stage result
- ex_stall  in  1  downstream hold
- flush  in  1  taken branch/jump resolved in EX
- id_stall  out  1  combinational; IF/ID must hold
- ex_valid  out  1  registered
- ex_alu_ctrl  out  5  registered
- ex_src_a, ex_src_b  out  32 each  registered
- ex_store_data  out  32  registered
- ex_pc  out  32  registered
- ex_branch_target  out  32  registered
- ex_rd  out  5  registered
- ex_funct3  out  3  registered
- ex_reg_write, ex_mem_read, ex_mem_write, ex_is_branch, ex_is_jal, ex_is_jalr, ex_illegal  out  1 each  registered

## Operation
- ALU opcode encoding:
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND
  - 10 BEQ, 11 BNE, 12 BLT, 13 BGE, 14 BLTU, 15 BGEU
  - 16 pass B, 17 (A+B)&~1
- Decode:
  - OP: a=rs1, b=rs2. funct7[5] selects SUB/SRA.
  - OP-IMM: a=rs1, b=immI. Shifts use b=shamt, zero-extended. funct7[5] selects SRAI.
  - LOAD: ADD, a=rs1, b=immI, mem_read, reg_write.
  - STORE: ADD, a=rs1, b=immS, mem_write, store_data=fwd rs2.
  - BRANCH: opcode 10–15 by funct3, a=rs1, b=rs2, branch_target=pc+immB.
  - LUI: 16, b=immU.
  - AUIPC: ADD, a=pc, b=immU.
  - JAL: ADD, a=pc, b=4, branch_target=pc+immJ, reg_write.
  - JALR: 17, a=rs1, b=immI, reg_write. EX computes link as ex_pc+4.
- Immediates are sign-extended from bit 31. All adds are modulo 2^32.
- Illegal or unsupported opcode, or invalid branch funct3:
  - ex_illegal=1, opcode 0
  - all write/mem/branch controls 0
- rd==0 forces ex_reg_write=0.
- Forwarding per source, rs1 and rs2 independently:
  - EX/MEM match (en & rd!=0 & rd==rs) wins over MEM/WB match.
  - Otherwise use register file data.
  - rs==x0 always yields 0.
- Load-use hazard: all of the following hold →
  - id_valid & ex_valid & ex_mem_read & ex_rd!=0
  - ex_rd equals an rs actually read by the ID instruction (rs2 only for OP/STORE/BRANCH; none for LUI/AUIPC/JAL)

## Timing
- Reset: every registered output is 0, including ex_valid=0 and ex_alu_ctrl=0.
- Latency: one cycle from ID to ex_* outputs.
- Next-state priority per edge: rst > flush > ex_stall > load-use > normal load.
  - flush: ex_valid←0, controls←0. Applies even when ex_stall=1.
  - ex_stall (no flush): all ex_* hold their values.
  - load-use (no stall/flush): bubble inserted; ex_valid←0, controls←0.
  - normal: load decoded values, ex_valid←id_valid.
- id_stall = !flush & (ex_stall | load_use).
  - Asserted for exactly one cycle per load-use with no other stall.
  - After the bubble, the load is in MEM and the value arrives via mem_fwd on the retry.
- id_valid=0 loads a bubble and never raises load_use.
- Reset asserted mid-stall clears all state. id_stall then follows the inputs combinationally (0 if ex_stall=0).

## Test plan
- Reset, then ADD x3,x1,x2 with rs1=5, rs2=7 → next cycle:
  - ex_valid=1, ctrl=0, a=5, b=7, rd=3, reg_write=1
- SRAI x1,x2,4 with rs1=0x80000000 → ctrl=7, b=4. SUB → ctrl=1. BGEU → ctrl=15, target=pc+immB (e.g. pc=0x100, imm=-8 → 0xF8).
- Forwarding, rs1=x5 with EX/MEM and MEM/WB both writing x5 (0xAA and 0xBB) → a=0xAA. With x0 as rs1 → a=0 even when forward rd=0.
- LW x5 in EX followed by ADD x6,x5,x1 in ID:
  - id_stall=1 for one cycle
  - a bubble is registered (ex_valid=0)
  - the ADD issues the next cycle with a=mem_fwd_data
- ex_stall=1 for 3 cycles → ex_* stable and id_stall=1. With flush=1 and ex_stall=1 on the same edge → ex_valid=0 and id_stall=0.
- JALR x1,8(x2), rs1=0x1001 → ctrl=17, a=0x1001, b=8. Opcode 0x7F → ex_illegal=1, reg_write=0.

Source files
------------

// File: rtl/alu_issue_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_issue_stage_if
//  Description : ID-side inputs, forwarding taps and ID/EX register outputs
//                of the ALU issue stage.
//  Revision    : 1.0
// ============================================================================
interface alu_issue_stage_if;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic [31:0] id_rs1_data;
    logic [31:0] id_rs2_data;
    logic        mem_fwd_en;
    logic [4:0]  mem_fwd_rd;
    logic [31:0] mem_fwd_data;
    logic        wb_fwd_en;
    logic [4:0]  wb_fwd_rd;
    logic [31:0] wb_fwd_data;
    logic        ex_stall;
    logic        flush;
    logic        id_stall;
    logic        ex_valid;
    logic [4:0]  ex_alu_ctrl;
    logic [31:0] ex_src_a;
    logic [31:0] ex_src_b;
    logic [31:0] ex_store_data;
    logic [31:0] ex_pc;
    logic [31:0] ex_branch_target;
    logic [4:0]  ex_rd;
    logic [2:0]  ex_funct3;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_is_branch;
    logic        ex_is_jal;
    logic        ex_is_jalr;
    logic        ex_illegal;

    modport master (
        output id_valid, id_inst, id_pc, id_rs1_data, id_rs2_data,
               mem_fwd_en, mem_fwd_rd, mem_fwd_data,
               wb_fwd_en, wb_fwd_rd, wb_fwd_data, ex_stall, flush,
        input  id_stall, ex_valid, ex_alu_ctrl, ex_src_a, ex_src_b,
               ex_store_data, ex_pc, ex_branch_target, ex_rd, ex_funct3,
               ex_reg_write, ex_mem_read, ex_mem_write, ex_is_branch,
               ex_is_jal, ex_is_jalr, ex_illegal
    );

    modport slave (
        input  id_valid, id_inst, id_pc, id_rs1_data, id_rs2_data,
               mem_fwd_en, mem_fwd_rd, mem_fwd_data,
               wb_fwd_en, wb_fwd_rd, wb_fwd_data, ex_stall, flush,
        output id_stall, ex_valid, ex_alu_ctrl, ex_src_a, ex_src_b,
               ex_store_data, ex_pc, ex_branch_target, ex_rd, ex_funct3,
               ex_reg_write, ex_mem_read, ex_mem_write, ex_is_branch,
               ex_is_jal, ex_is_jalr, ex_illegal
    );
endinterface
`default_nettype wire

// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
//  Module      : alu_issue_stage
//  Description : RV32I ID/EX issue stage - decode, forwarding, load-use
//                detection and the ID/EX pipeline register.
//  Revision    : 1.0
// ============================================================================
module alu_issue_stage (
    input  logic              clk,
    input  logic              rst,
    alu_issue_stage_if.slave  bus
);
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_SLL  = 5'd2;
    localparam logic [4:0] ALU_SLT  = 5'd3;
    localparam logic [4:0] ALU_SLTU = 5'd4;
    localparam logic [4:0] ALU_XOR  = 5'd5;
    localparam logic [4:0] ALU_SRL  = 5'd6;
    localparam logic [4:0] ALU_SRA  = 5'd7;
    localparam logic [4:0] ALU_OR   = 5'd8;
    localparam logic [4:0] ALU_AND  = 5'd9;
    localparam logic [4:0] ALU_BEQ  = 5'd10;
    localparam logic [4:0] ALU_BNE  = 5'd11;
    localparam logic [4:0] ALU_BLT  = 5'd12;
    localparam logic [4:0] ALU_BGE  = 5'd13;
    localparam logic [4:0] ALU_BLTU = 5'd14;
    localparam logic [4:0] ALU_BGEU = 5'd15;
    localparam logic [4:0] ALU_PASS = 5'd16;
    localparam logic [4:0] ALU_JALR = 5'd17;

    logic [31:0] w_inst;
    logic [6:0]  w_opc;
    logic [4:0]  w_rd, w_rs1, w_rs2;
    logic [2:0]  w_f3;
    logic        w_alt;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
    logic [31:0] w_rs1_val, w_rs2_val;

    assign w_inst  = bus.id_inst;
    assign w_opc   = w_inst[6:0];
    assign w_rd    = w_inst[11:7];
    assign w_f3    = w_inst[14:12];
    assign w_rs1   = w_inst[19:15];
    assign w_rs2   = w_inst[24:20];
    assign w_alt   = w_inst[30];
    assign w_imm_i = {{20{w_inst[31]}}, w_inst[31:20]};
    assign w_imm_s = {{20{w_inst[31]}}, w_inst[31:25], w_inst[11:7]};
    assign w_imm_b = {{19{w_inst[31]}}, w_inst[31], w_inst[7], w_inst[30:25], w_inst[11:8], 1'b0};
    assign w_imm_u = {w_inst[31:12], 12'd0};
    assign w_imm_j = {{11{w_inst[31]}}, w_inst[31], w_inst[19:12], w_inst[20], w_inst[30:21], 1'b0};

    // The EX/MEM result is younger than MEM/WB, so it takes precedence.
    always_comb begin
        w_rs1_val = bus.id_rs1_data;
        if (w_rs1 == 5'd0)
            w_rs1_val = '0;
        else if (bus.mem_fwd_en && bus.mem_fwd_rd == w_rs1)
            w_rs1_val = bus.mem_fwd_data;
        else if (bus.wb_fwd_en && bus.wb_fwd_rd == w_rs1)
            w_rs1_val = bus.wb_fwd_data;
    end

    always_comb begin
        w_rs2_val = bus.id_rs2_data;
        if (w_rs2 == 5'd0)
            w_rs2_val = '0;
        else if (bus.mem_fwd_en && bus.mem_fwd_rd == w_rs2)
            w_rs2_val = bus.mem_fwd_data;
        else if (bus.wb_fwd_en && bus.wb_fwd_rd == w_rs2)
            w_rs2_val = bus.wb_fwd_data;
    end

    logic [4:0]  w_ctrl;
    logic [31:0] w_a, w_b, w_sd, w_tgt;
    logic [4:0]  w_dst;
    logic        w_rw, w_mr, w_mw, w_br, w_jal, w_jalr, w_ill;
    logic        w_use_rs1, w_use_rs2;

    always_comb begin
        w_ctrl    = ALU_ADD;
        w_a       = '0;
        w_b       = '0;
        w_sd      = '0;
        w_tgt     = '0;
        w_dst     = '0;
        w_rw      = 1'b0;
        w_mr      = 1'b0;
        w_mw      = 1'b0;
        w_br      = 1'b0;
        w_jal     = 1'b0;
        w_jalr    = 1'b0;
        w_ill     = 1'b0;
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
        case (w_opc)
            OPC_OP, OPC_OPIMM: begin
                w_use_rs1 = 1'b1;
                w_use_rs2 = (w_opc == OPC_OP);
                w_a       = w_rs1_val;
                w_dst     = w_rd;
                w_rw      = 1'b1;
                if (w_opc == OPC_OP)
                    w_b = w_rs2_val;
                else if (w_f3 == 3'b001 || w_f3 == 3'b101)
                    w_b = {27'd0, w_inst[24:20]};
                else
                    w_b = w_imm_i;
                case (w_f3)
                    3'b000:  w_ctrl = (w_alt && w_opc == OPC_OP) ? ALU_SUB : ALU_ADD;
                    3'b001:  w_ctrl = ALU_SLL;
                    3'b010:  w_ctrl = ALU_SLT;
                    3'b011:  w_ctrl = ALU_SLTU;
                    3'b100:  w_ctrl = ALU_XOR;
                    3'b101:  w_ctrl = w_alt ? ALU_SRA : ALU_SRL;
                    3'b110:  w_ctrl = ALU_OR;
                    default: w_ctrl = ALU_AND;
                endcase
            end
            OPC_LOAD: begin
                w_use_rs1 = 1'b1;
                w_a       = w_rs1_val;
                w_b       = w_imm_i;
                w_dst     = w_rd;
                w_rw      = 1'b1;
                w_mr      = 1'b1;
            end
            OPC_STORE: begin
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_a       = w_rs1_val;
                w_b       = w_imm_s;
                w_sd      = w_rs2_val;
                w_mw      = 1'b1;
            end
            OPC_BRANCH: begin
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                case (w_f3)
                    3'b000:  w_ctrl = ALU_BEQ;
                    3'b001:  w_ctrl = ALU_BNE;
                    3'b100:  w_ctrl = ALU_BLT;
                    3'b101:  w_ctrl = ALU_BGE;
                    3'b110:  w_ctrl = ALU_BLTU;
                    3'b111:  w_ctrl = ALU_BGEU;
                    default: w_ill  = 1'b1;
                endcase
                if (!w_ill) begin
                    w_a   = w_rs1_val;
                    w_b   = w_rs2_val;
                    w_tgt = bus.id_pc + w_imm_b;
                    w_br  = 1'b1;
                end
            end
            OPC_LUI: begin
                w_ctrl = ALU_PASS;
                w_b    = w_imm_u;
                w_dst  = w_rd;
                w_rw   = 1'b1;
            end
            OPC_AUIPC: begin
                w_a   = bus.id_pc;
                w_b   = w_imm_u;
                w_dst = w_rd;
                w_rw  = 1'b1;
            end
            OPC_JAL: begin
                w_a   = bus.id_pc;
                w_b   = 32'd4;
                w_tgt = bus.id_pc + w_imm_j;
                w_dst = w_rd;
                w_rw  = 1'b1;
                w_jal = 1'b1;
            end
            OPC_JALR: begin
                w_use_rs1 = 1'b1;
                w_ctrl    = ALU_JALR;
                w_a       = w_rs1_val;
                w_b       = w_imm_i;
                w_dst     = w_rd;
                w_rw      = 1'b1;
                w_jalr    = 1'b1;
            end
            default: w_ill = 1'b1;
        endcase
        if (w_rd == 5'd0)
            w_rw = 1'b0;
    end

    logic w_load_use;
    logic w_bubble;

    assign w_load_use = bus.id_valid && bus.ex_valid && bus.ex_mem_read && (bus.ex_rd != 5'd0)
                        && ((w_use_rs1 && w_rs1 == bus.ex_rd) || (w_use_rs2 && w_rs2 == bus.ex_rd));

    assign bus.id_stall = !bus.flush && (bus.ex_stall || w_load_use);

    // Flush overrides a downstream hold; otherwise a hold freezes the register.
    assign w_bubble = bus.flush || (!bus.ex_stall && (w_load_use || !bus.id_valid));

    always_ff @(posedge clk) begin
        if (rst || w_bubble) begin
            bus.ex_valid         <= 1'b0;
            bus.ex_alu_ctrl      <= '0;
            bus.ex_src_a         <= '0;
            bus.ex_src_b         <= '0;
            bus.ex_store_data    <= '0;
            bus.ex_pc            <= '0;
            bus.ex_branch_target <= '0;
            bus.ex_rd            <= '0;
            bus.ex_funct3        <= '0;
            bus.ex_reg_write     <= 1'b0;
            bus.ex_mem_read      <= 1'b0;
            bus.ex_mem_write     <= 1'b0;
            bus.ex_is_branch     <= 1'b0;
            bus.ex_is_jal        <= 1'b0;
            bus.ex_is_jalr       <= 1'b0;
            bus.ex_illegal       <= 1'b0;
        end else if (!bus.ex_stall) begin
            bus.ex_valid         <= 1'b1;
            bus.ex_alu_ctrl      <= w_ctrl;
            bus.ex_src_a         <= w_a;
            bus.ex_src_b         <= w_b;
            bus.ex_store_data    <= w_sd;
            bus.ex_pc            <= bus.id_pc;
            bus.ex_branch_target <= w_tgt;
            bus.ex_rd            <= w_dst;
            bus.ex_funct3        <= w_f3;
            bus.ex_reg_write     <= w_rw;
            bus.ex_mem_read      <= w_mr;
            bus.ex_mem_write     <= w_mw;
            bus.ex_is_branch     <= w_br;
            bus.ex_is_jal        <= w_jal;
            bus.ex_is_jalr       <= w_jalr;
            bus.ex_illegal       <= w_ill;
        end
    end
endmodule
`default_nettype wire
